// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA decoder: default operand width and FSM state encoding.
package rsa_pkg;

    localparam int RSA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MULT,
        SQUARE,
        FIN
    } rsa_state_e;

endpackage

// File: rtl/cla_add8.sv
// 8-bit carry-lookahead adder, plus a chained wrapper for arbitrary operand widths.
module cla_add8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       t;
    logic       c_acc;

    // Each carry is expanded as the OR of every generate term propagated up to it.
    always_comb begin
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        c[0]  = cin;
        t     = 1'b0;
        c_acc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            t = cin;
            for (int k = 0; k <= i; k++) t = t & p[k];
            c_acc = t;
            for (int j = 0; j <= i; j++) begin
                t = g[j];
                for (int k = j + 1; k <= i; k++) t = t & p[k];
                c_acc = c_acc | t;
            end
            c[i+1] = c_acc;
        end
        sum  = p ^ c[7:0];
        cout = c[8];
    end
endmodule

module cla_addn #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    localparam int NB = (W + 7) / 8;

    logic [NB*8-1:0] a_pad;
    logic [NB*8-1:0] b_pad;
    logic [NB*8-1:0] s_pad;
    logic [NB:0]     cy;
    logic [NB*8:0]   full;

    assign a_pad = (NB*8)'(a);
    assign b_pad = (NB*8)'(b);
    assign cy[0] = cin;

    for (genvar gi = 0; gi < NB; gi++) begin : g_blk
        cla_add8 u_add (
            .a   (a_pad[8*gi +: 8]),
            .b   (b_pad[8*gi +: 8]),
            .cin (cy[gi]),
            .sum (s_pad[8*gi +: 8]),
            .cout(cy[gi+1])
        );
    end

    // Operands are zero-padded, so at most one bit at or above W can be set: the true carry out.
    assign full = {cy[NB], s_pad};
    assign sum  = s_pad[W-1:0];
    assign cout = |full[NB*8:W];
endmodule

// File: rtl/mod_mult_step.sv
// One MSB-first interleaved modular multiply step: acc' = 2*acc mod n, then + b mod n if op_bit.
module mod_mult_step
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] b,
    input  logic             op_bit,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH:0]   acc_next
);
    localparam int W1 = WIDTH + 1;

    logic [W1-1:0] dbl;
    logic [W1-1:0] n_inv;
    logic [W1-1:0] b_ext;
    logic [W1-1:0] d1;
    logic [W1-1:0] r1;
    logic [W1-1:0] s;
    logic [W1-1:0] d2;
    logic [W1-1:0] add_r;
    logic          c1;
    logic          cs;
    logic          c2;

    assign dbl   = {acc[WIDTH-1:0], 1'b0};
    assign n_inv = ~{1'b0, n};
    assign b_ext = {1'b0, b};

    cla_addn #(.W(W1)) u_sub_dbl (.a(dbl), .b(n_inv), .cin(1'b1), .sum(d1), .cout(c1));

    // acc[WIDTH] set would mean the doubled value overflowed W1 bits, so it is certainly >= n.
    assign r1 = (c1 | acc[WIDTH]) ? d1 : dbl;

    cla_addn #(.W(W1)) u_add_b   (.a(r1), .b(b_ext), .cin(1'b0), .sum(s),  .cout(cs));
    cla_addn #(.W(W1)) u_sub_add (.a(s),  .b(n_inv), .cin(1'b1), .sum(d2), .cout(c2));

    assign add_r    = (c2 | cs) ? d2 : s;
    assign acc_next = op_bit ? add_r : r1;
endmodule

// File: rtl/rsa_decoder.sv
// Sequential RSA decode m = c^d mod n using right-to-left square-and-multiply.
// RSA_DECODER_CONST_TIME_EN: always process all WIDTH exponent bits.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold last result
// LOAD   | base = c mod n (Horner reduction, WIDTH cycles)
// MULT   | result = result*base mod n when current exponent bit set (WIDTH cycles)
// SQUARE | base = base*base mod n (WIDTH cycles), then advance exponent
// FIN    | publish result/err, pulse done
module rsa_decoder
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] cipher,
    input  logic [WIDTH-1:0] d_key,
    input  logic [WIDTH-1:0] n_mod,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] plain,
    output logic             err
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    rsa_state_e       state_q, state_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] e_q, e_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    ebit_q, ebit_d;
    logic             bad_q, bad_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] plain_q, plain_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] step_b;
    logic             step_bit;
    logic [WIDTH:0]   step_acc;
    logic             cnt_tc;

    mod_mult_step #(.WIDTH(WIDTH)) u_step (
        .acc     (acc_q),
        .b       (step_b),
        .op_bit  (step_bit),
        .n       (n_q),
        .acc_next(step_acc)
    );

    assign cnt_tc = (cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        e_d      = e_q;
        n_d      = n_q;
        base_d   = base_q;
        result_d = result_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ebit_d   = ebit_q;
        bad_d    = bad_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        plain_d  = plain_q;
        err_d    = err_q;
        step_b   = '0;
        step_bit = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    c_d      = cipher;
                    e_d      = d_key;
                    n_d      = n_mod;
                    base_d   = '0;
                    result_d = WIDTH'(1);
                    acc_d    = '0;
                    cnt_d    = CNT_LAST;
                    ebit_d   = CNT_LAST;
                    busy_d   = 1'b1;
                    bad_d    = (n_mod < WIDTH'(2));
                    state_d  = (n_mod < WIDTH'(2)) ? FIN : LOAD;
                end
            end
            LOAD: begin
                // c mod n as Horner's rule over the bits of c with a unit addend
                step_bit = c_q[cnt_q];
                step_b   = WIDTH'(1);
                if (cnt_tc) begin
                    base_d = step_acc[WIDTH-1:0];
                    acc_d  = '0;
                    cnt_d  = CNT_LAST;
`ifdef RSA_DECODER_CONST_TIME_EN
                    state_d = MULT;
`else
                    state_d = (e_q == '0) ? FIN : MULT;
`endif
                end else begin
                    acc_d = step_acc;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            MULT: begin
                step_bit = result_q[cnt_q];
                step_b   = base_q;
                if (cnt_tc) begin
                    if (e_q[0]) result_d = step_acc[WIDTH-1:0];
                    acc_d   = '0;
                    cnt_d   = CNT_LAST;
                    state_d = SQUARE;
                end else begin
                    acc_d = step_acc;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SQUARE: begin
                step_bit = base_q[cnt_q];
                step_b   = base_q;
                if (cnt_tc) begin
                    base_d = step_acc[WIDTH-1:0];
                    e_d    = e_q >> 1;
                    acc_d  = '0;
                    cnt_d  = CNT_LAST;
`ifdef RSA_DECODER_CONST_TIME_EN
                    if (ebit_q == '0) begin
                        state_d = FIN;
                    end else begin
                        ebit_d  = ebit_q - 1'b1;
                        state_d = MULT;
                    end
`else
                    state_d = ((e_q >> 1) == '0) ? FIN : MULT;
`endif
                end else begin
                    acc_d = step_acc;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                err_d   = bad_q;
                plain_d = bad_q ? '0 : result_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            c_q      <= '0;
            e_q      <= '0;
            n_q      <= '0;
            base_q   <= '0;
            result_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            ebit_q   <= '0;
            bad_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            plain_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            e_q      <= e_d;
            n_q      <= n_d;
            base_q   <= base_d;
            result_q <= result_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ebit_q   <= ebit_d;
            bad_q    <= bad_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            plain_q  <= plain_d;
            err_q    <= err_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign plain = plain_q;
    assign err   = err_q;
endmodule
